sb_io_cell: RTL and testbench

//   Configurable bidirectional pad cell: per-bit tristate output driver plus input capture.

---
 rtl/sb_io_cell_if.sv | 46 ++++
 rtl/sb_io_cell.sv | 119 +++++++++++
 tb/tb_sb_io_cell.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_io_cell_if.sv
// -----------------------------------------------------------------------------
// sb_io_cell_if
//   Core-side signal bundle of the sb_io_cell pad cell. The physical pad
//   (inout) is not part of this bundle; it stays a plain port on the cell.
//
//   Parameters:
//     WIDTH          number of pad bits carried by the data vectors
//   Signals:
//     clock_enable   1 = cell registers load on their edge, 0 = hold
//     output_enable  tristate control shared by all bits
//     d_out_0        output data (rising-edge / simple data)
//     d_out_1        falling-edge output data (DDR builds only)
//     d_in_0         input data (rising-edge / simple data)
//     d_in_1         falling-edge input data (DDR builds only, else 0)
//   Modports:
//     master         core logic driving the cell
//     slave          the pad cell itself
// -----------------------------------------------------------------------------
interface sb_io_cell_if #(
    parameter int WIDTH = 1
);
    logic             clock_enable;
    logic             output_enable;
    logic [WIDTH-1:0] d_out_0;
    logic [WIDTH-1:0] d_out_1;
    logic [WIDTH-1:0] d_in_0;
    logic [WIDTH-1:0] d_in_1;

    modport master (
        output clock_enable,
        output output_enable,
        output d_out_0,
        output d_out_1,
        input  d_in_0,
        input  d_in_1
    );

    modport slave (
        input  clock_enable,
        input  output_enable,
        input  d_out_0,
        input  d_out_1,
        output d_in_0,
        output d_in_1
    );
endinterface

// File: rtl/sb_io_cell.sv
// -----------------------------------------------------------------------------
// sb_io_cell
//   Configurable bidirectional pad cell: per-bit tristate driver plus input
//   capture. The core only sees d_out/d_in/output_enable through the bus
//   interface; the inout pin is handled here.
//
//   Parameters:
//     WIDTH     number of independent pad bits (shared configuration)
//     PIN_TYPE  [5:4] OE mode    00 never, 01 always, 10 output_enable,
//                                11 registered output_enable
//               [3:2] out mode   10 d_out_0, 01 registered d_out_0,
//                                11 inverted registered d_out_0, 00 DDR
//               [1:0] in mode    bit0=1 combinational, bit0=0 registered
//     PULLUP    1 = weak pull-up on every pad bit
//   Ports:
//     clock        rising edge for all registers (falling edge for DDR regs)
//     reset        asynchronous, active-high; clears every register
//     package_pin  external pad vector (inout)
//     bus          core-side signals (sb_io_cell_if.slave)
//   Build option:
//     SB_IO_DDR_EN  when defined, output mode 00 is true DDR (d_out_1 driven
//                   while clock is low) and registered inputs also capture on
//                   the falling edge into d_in_1. When undefined, output mode
//                   00 behaves as 01, d_out_1 is ignored and d_in_1 is 0.
// -----------------------------------------------------------------------------
module sb_io_cell #(
    parameter int         WIDTH    = 1,
    parameter logic [5:0] PIN_TYPE = 6'b101001,
    parameter bit         PULLUP   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] package_pin,
    sb_io_cell_if.slave      bus
);

    localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];
    localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
    localparam bit         IN_COMB  = PIN_TYPE[0];

    logic             oe_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] in_reg;
    logic [WIDTH-1:0] ddr_val;
    logic [WIDTH-1:0] out_val;
    logic             drive_en;

    // Rising-edge registers. in_reg samples the resolved pad, so it also
    // captures the cell's own driven value (loopback).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oe_reg  <= 1'b0;
            out_reg <= '0;
            in_reg  <= '0;
        end else if (bus.clock_enable) begin
            oe_reg  <= bus.output_enable;
            out_reg <= bus.d_out_0;
            in_reg  <= package_pin;
        end
    end

`ifdef SB_IO_DDR_EN
    logic [WIDTH-1:0] out_f_reg;
    logic [WIDTH-1:0] in_f_reg;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            out_f_reg <= '0;
            in_f_reg  <= '0;
        end else if (bus.clock_enable) begin
            out_f_reg <= bus.d_out_1;
            in_f_reg  <= package_pin;
        end
    end

    // High phase shows the rising-edge data, low phase the falling-edge data.
    assign ddr_val    = clock ? out_reg : out_f_reg;
    assign bus.d_in_1 = IN_COMB ? '0 : in_f_reg;
`else
    logic unused_d_out_1;

    assign unused_d_out_1 = ^bus.d_out_1;
    assign ddr_val        = out_reg;
    assign bus.d_in_1     = '0;
`endif

    always_comb begin
        drive_en = 1'b0;
        case (OE_MODE)
            2'b00:   drive_en = 1'b0;
            2'b01:   drive_en = 1'b1;
            2'b10:   drive_en = bus.output_enable;
            default: drive_en = oe_reg;
        endcase
    end

    always_comb begin
        out_val = out_reg;
        case (OUT_MODE)
            2'b10:   out_val = bus.d_out_0;
            2'b01:   out_val = out_reg;
            2'b11:   out_val = ~out_reg;
            default: out_val = ddr_val;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pad
            assign package_pin[gi] = drive_en ? out_val[gi] : 1'bz;
            if (PULLUP) begin : g_pullup
                pullup pu_i (package_pin[gi]);
            end
        end
    endgenerate

    assign bus.d_in_0 = IN_COMB ? package_pin : in_reg;

endmodule

// File: tb/tb_sb_io_cell.sv
// -----------------------------------------------------------------------------
// tb_sb_io_cell
//   Self-checking bench for sb_io_cell. Several cells with different
//   configurations share one clock and reset:
//     u_a  16 bit, OE=output_enable, out=d_out_0, in=combinational
//     u_b   4 bit, OE registered,   out registered, in registered
//     u_c   1 bit, always drive,    out inverted registered, in comb
//     u_d   1 bit, never drive,     pull-up, in comb
//     u_e   1 bit, always drive,    out mode 00 (DDR / registered), in comb
// -----------------------------------------------------------------------------
module tb_sb_io_cell;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    sb_io_cell_if #(.WIDTH(16)) ifa ();
    sb_io_cell_if #(.WIDTH(4))  ifb ();
    sb_io_cell_if #(.WIDTH(1))  ifc ();
    sb_io_cell_if #(.WIDTH(1))  ifd ();
    sb_io_cell_if #(.WIDTH(1))  ife ();

    wire [15:0] pad_a;
    wire [3:0]  pad_b;
    wire        pad_c;
    wire        pad_d;
    wire        pad_e;

    logic        tb_a_en;
    logic [15:0] tb_a_val;
    logic        tb_b_en;
    logic [3:0]  tb_b_val;

    // External board drivers for the pads that can be driven from outside.
    assign pad_a = tb_a_en ? tb_a_val : 16'bz;
    assign pad_b = tb_b_en ? tb_b_val : 4'bz;

    sb_io_cell #(.WIDTH(16), .PIN_TYPE(6'b101001), .PULLUP(1'b0)) u_a (
        .clock(clock), .reset(reset), .package_pin(pad_a), .bus(ifa));
    sb_io_cell #(.WIDTH(4), .PIN_TYPE(6'b110100), .PULLUP(1'b0)) u_b (
        .clock(clock), .reset(reset), .package_pin(pad_b), .bus(ifb));
    sb_io_cell #(.WIDTH(1), .PIN_TYPE(6'b011101), .PULLUP(1'b0)) u_c (
        .clock(clock), .reset(reset), .package_pin(pad_c), .bus(ifc));
    sb_io_cell #(.WIDTH(1), .PIN_TYPE(6'b000001), .PULLUP(1'b1)) u_d (
        .clock(clock), .reset(reset), .package_pin(pad_d), .bus(ifd));
    sb_io_cell #(.WIDTH(1), .PIN_TYPE(6'b010001), .PULLUP(1'b0)) u_e (
        .clock(clock), .reset(reset), .package_pin(pad_e), .bus(ife));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // The pad must not be driven by the cell: it must not show the value the
    // cell would drive if its driver were on.
    task automatic check_float(input string name, input logic [31:0] act, input logic [31:0] driven);
        checks++;
        if (act === driven) begin
            errors++;
            $display("FAIL %s actual=%0h expected=undriven (not %0h)", name, act, driven);
        end else begin
            $display("ok   %s undriven value=%0h", name, act);
        end
    endtask

    typedef struct {
        logic        oe;
        logic [15:0] d_out;
        logic        ext_en;
        logic [15:0] ext_val;
        logic [15:0] exp_pad;
        logic [15:0] exp_din;
    } vec_t;

    vec_t vecs [6];

    // Reference state for u_b: values captured at the last enabled rising edge.
    logic       m_oe;
    logic [3:0] m_out;
    logic [3:0] m_in;
    bit         m_in_known;

    initial begin
        vecs[0] = '{1'b1, 16'h5A5A, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{1'b0, 16'h1234, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 16'h0001, 1'b0, 16'hFFFF, 16'h0001, 16'h0001};
        vecs[5] = '{1'b0, 16'hFFFF, 1'b1, 16'h8001, 16'h8001, 16'h8001};

        reset    = 1'b1;
        tb_a_en  = 1'b0;
        tb_a_val = '0;
        tb_b_en  = 1'b0;
        tb_b_val = '0;
        ifa.clock_enable = 1'b1; ifa.output_enable = 1'b0; ifa.d_out_0 = '0; ifa.d_out_1 = '0;
        ifb.clock_enable = 1'b1; ifb.output_enable = 1'b1; ifb.d_out_0 = 4'hF; ifb.d_out_1 = '0;
        ifc.clock_enable = 1'b1; ifc.output_enable = 1'b0; ifc.d_out_0 = 1'b1; ifc.d_out_1 = '0;
        ifd.clock_enable = 1'b1; ifd.output_enable = 1'b1; ifd.d_out_0 = 1'b0; ifd.d_out_1 = '0;
        ife.clock_enable = 1'b1; ife.output_enable = 1'b0; ife.d_out_0 = 1'b1; ife.d_out_1 = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clock);
        #1;
        check_float("rst_b_pad_float", {28'd0, pad_b}, 32'hF);
        check("rst_b_din", {28'd0, ifb.d_in_0}, 32'h0);
        check("rst_c_pad_inv", {31'd0, pad_c}, 32'h1);
        check("rst_c_loopback", {31'd0, ifc.d_in_0}, 32'h1);
        check("pullup_d_din", {31'd0, ifd.d_in_0}, 32'h1);
        check("pullup_d_pad", {31'd0, pad_d}, 32'h1);

        // ---- registered OE: still undriven until the first rising edge ----
        reset = 1'b0;
        #1;
        check_float("b_oe_wait_edge", {28'd0, pad_b}, 32'hF);
        @(posedge clock); #1;
        check("b_oe_after_edge", {28'd0, pad_b}, 32'hF);
        check("c_inv_after_edge", {31'd0, pad_c}, 32'h0);
        check("c_loopback_after_edge", {31'd0, ifc.d_in_0}, 32'h0);

        // ---- output mode 00: high phase then low phase ----
        @(posedge clock); #1;
        check("e_pad_high_phase", {31'd0, pad_e}, 32'h1);
        @(negedge clock); #1;
`ifdef SB_IO_DDR_EN
        check("e_pad_low_phase_ddr", {31'd0, pad_e}, 32'h0);
`else
        check("e_pad_low_phase", {31'd0, pad_e}, 32'h1);
`endif
        check("e_din1_zero", {31'd0, ife.d_in_1}, 32'h0);

        // ---- asynchronous reset mid-cycle ----
        #1;
        reset = 1'b1;
        #1;
        check_float("async_rst_b_float", {28'd0, pad_b}, 32'hF);
        check("async_rst_b_din", {28'd0, ifb.d_in_0}, 32'h0);
        check("async_rst_c_pad", {31'd0, pad_c}, 32'h1);
        check("async_rst_e_pad", {31'd0, pad_e}, 32'h0);
        reset = 1'b0;

        // ---- registered input: mid-cycle toggle, then clock_enable hold ----
        ifb.output_enable = 1'b0;
        tb_b_en  = 1'b1;
        tb_b_val = 4'h0;
        @(posedge clock);
        @(negedge clock);
        tb_b_val = 4'hF;
        #1;
        check("b_in_mid_cycle_hold", {28'd0, ifb.d_in_0}, 32'h0);
        check("b_pad_ext", {28'd0, pad_b}, 32'hF);
        @(posedge clock); #1;
        check("b_in_after_edge", {28'd0, ifb.d_in_0}, 32'hF);
        @(negedge clock);
        ifb.clock_enable  = 1'b0;
        ifb.output_enable = 1'b1;
        tb_b_val = 4'h0;
        @(posedge clock); #1;
        check("b_ce_hold_in", {28'd0, ifb.d_in_0}, 32'hF);
        check("b_ce_hold_oe", {28'd0, pad_b}, 32'h0);
`ifndef SB_IO_DDR_EN
        check("b_din1_zero", {28'd0, ifb.d_in_1}, 32'h0);
`endif
        @(negedge clock);
        ifb.clock_enable  = 1'b1;
        ifb.output_enable = 1'b0;

        // ---- table vectors on the combinational cell ----
        for (int i = 0; i < 6; i++) begin
            ifa.output_enable = vecs[i].oe;
            ifa.d_out_0       = vecs[i].d_out;
            tb_a_en           = vecs[i].ext_en;
            tb_a_val          = vecs[i].ext_val;
            #1;
            check($sformatf("a_vec%0d_pad", i), {16'd0, pad_a}, {16'd0, vecs[i].exp_pad});
            check($sformatf("a_vec%0d_din", i), {16'd0, ifa.d_in_0}, {16'd0, vecs[i].exp_din});
        end
        check("a_din1_zero", {16'd0, ifa.d_in_1}, 32'h0);

        // ---- random: combinational cell, pad = whoever drives it ----
        for (int i = 0; i < 40; i++) begin
            logic        oe_v;
            logic [15:0] d_v;
            logic [15:0] x_v;
            logic [15:0] exp_v;
            oe_v = 1'($urandom);
            d_v  = 16'($urandom);
            x_v  = 16'($urandom);
            ifa.output_enable = oe_v;
            ifa.d_out_0       = d_v;
            tb_a_en           = ~oe_v;
            tb_a_val          = x_v;
            exp_v = oe_v ? d_v : x_v;
            #2;
            check($sformatf("a_rand%0d_pad", i), {16'd0, pad_a}, {16'd0, exp_v});
            check($sformatf("a_rand%0d_din", i), {16'd0, ifa.d_in_0}, {16'd0, exp_v});
        end
        tb_a_en = 1'b0;

        // ---- random: fully registered cell against the reference state ----
        @(negedge clock);
        tb_b_en = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_oe = 1'b0; m_out = 4'h0; m_in = 4'h0; m_in_known = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic       oe_v;
            logic       ce_v;
            logic [3:0] d_v;
            logic [3:0] x_v;
            logic       ext_v;
            logic [3:0] pad_exp;
            bit         pad_known;
            oe_v  = 1'($urandom);
            ce_v  = ($urandom_range(3) != 0);
            d_v   = 4'($urandom);
            x_v   = 4'($urandom);
            // Drive externally only when the cell is guaranteed to stay off
            // through the next rising edge.
            ext_v = !m_oe && !(ce_v && oe_v);
            ifb.output_enable = oe_v;
            ifb.clock_enable  = ce_v;
            ifb.d_out_0       = d_v;
            tb_b_en           = ext_v;
            tb_b_val          = x_v;
            pad_known = 1'b1;
            if (m_oe)       pad_exp = m_out;
            else if (ext_v) pad_exp = x_v;
            else begin
                pad_exp   = 4'h0;
                pad_known = 1'b0;
            end
            #1;
            if (pad_known)
                check($sformatf("b_rand%0d_pad", i), {28'd0, pad_b}, {28'd0, pad_exp});
            if (m_in_known)
                check($sformatf("b_rand%0d_din", i), {28'd0, ifb.d_in_0}, {28'd0, m_in});
            @(posedge clock);
            if (ce_v) begin
                m_oe       = oe_v;
                m_out      = d_v;
                m_in       = pad_exp;
                m_in_known = pad_known;
            end
            @(negedge clock);
            #1;
        end
        tb_b_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
